noc_output_scheduler: RTL

- Per-output-port scheduler for the NoC router. It shares one 20-bit output link between NUM_REQ input requesters (N/S/E/W/Local).
- Uses round-robin arbitration with packet locking: a granted requester owns the link until its tail flit is sent.
- Gates every send on a downstream credit counter, using the same credit-return (ci) protocol as the processor-element interface.
- Sits between the input buffers and the output link register of each router port.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/noc_output_scheduler_if.sv | 31 +++
 rtl/noc_output_scheduler_rr_arbiter.sv | 34 +++
 rtl/noc_output_scheduler.sv | 129 ++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router constants, FSM state type and credit-counter sizing helper.
package noc_pkg;

  localparam int DATA_W    = 20;
  localparam int CREDITS   = 4;
  localparam int NUM_PORTS = 5;

  localparam int PORT_N = 0;
  localparam int PORT_S = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // The counter must hold every value from 0 up to and including the buffer depth.
  function automatic int credit_cnt_w(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/noc_output_scheduler_if.sv
// Request/grant, credit-return and output-link signals of one router output port.
interface noc_output_scheduler_if #(
  parameter int NUM_REQ = noc_pkg::NUM_PORTS,
  parameter int DATA_W  = noc_pkg::DATA_W,
  parameter int CREDITS = noc_pkg::CREDITS
) ();

  localparam int CNT_W = noc_pkg::credit_cnt_w(CREDITS);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_tail;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      ci;
  logic [DATA_W-1:0]         dataout;
  logic                      out_valid;
  logic                      busy;
  logic [CNT_W-1:0]          credit_cnt;
  logic                      credit_err;

  modport master (
    output req, req_tail, req_data, ci,
    input  grant, dataout, out_valid, busy, credit_cnt, credit_err
  );

  modport slave (
    input  req, req_tail, req_data, ci,
    output grant, dataout, out_valid, busy, credit_cnt, credit_err
  );

endinterface

// File: rtl/noc_output_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = noc_pkg::NUM_PORTS,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  int               cand;
  logic [PTR_W-1:0] cand_idx;

  // NOTE: every combinational output gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(ptr_i) + k) % NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_output_scheduler.sv
// Output-port scheduler: round-robin with packet locking, gated by downstream credits.
module noc_output_scheduler #(
  parameter int NUM_REQ = noc_pkg::NUM_PORTS,
  parameter int DATA_W  = noc_pkg::DATA_W,
  parameter int CREDITS = noc_pkg::CREDITS
) (
  input logic                   clk,
  input logic                   RST,
  noc_output_scheduler_if.slave bus
);

  import noc_pkg::state_e;
  import noc_pkg::IDLE;
  import noc_pkg::LOCKED;
  import noc_pkg::credit_cnt_w;

  localparam int               PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int               CNT_W   = credit_cnt_w(CREDITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   credit_q, credit_d;
  logic               credit_err_q, credit_err_d;
  logic [DATA_W-1:0]  dataout_q;
  logic               out_valid_q;

  logic               can_send;
  logic               send;
  logic [PTR_W-1:0]   sel;
  logic [NUM_REQ-1:0] grant;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // The registered count gates sends; a credit returning this cycle only helps next cycle.
  assign can_send = (credit_q != '0);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    send         = 1'b0;
    sel          = owner_q;
    grant        = '0;

    if (!RST && can_send) begin
      unique case (state_q)
        IDLE: begin
          send  = arb_any;
          sel   = arb_idx;
          grant = arb_gnt;
        end
        LOCKED: begin
          send = bus.req[owner_q];
          if (send) grant = NUM_REQ'(1) << owner_q;
        end
        default: ;
      endcase
    end

    if (send) begin
      if (bus.req_tail[sel]) begin
        state_d  = IDLE;
        rr_ptr_d = next_ptr(sel);
      end else begin
        state_d = LOCKED;
        owner_d = sel;
      end
    end

    unique case ({send, bus.ci})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CNT_MAX) credit_err_d = 1'b1;
        else                     credit_d     = credit_q + 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      credit_q     <= CNT_MAX;
      credit_err_q <= 1'b0;
      dataout_q    <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      out_valid_q  <= send;
      if (send) dataout_q <= bus.req_data[sel*DATA_W +: DATA_W];
    end
  end

  assign bus.grant      = grant;
  assign bus.dataout    = dataout_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state_q == LOCKED);
  assign bus.credit_cnt = credit_q;
  assign bus.credit_err = credit_err_q;

endmodule
